// File: rtl/sub_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface sub_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, out, borrow_out, overflow, zero
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, out, borrow_out, overflow, zero
  );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = a - b - borrow_in, one full-subtractor cell
// plus a borrow flip-flop, LSB first over WIDTH cycles.
module sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  sub_serial_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    count;
  logic             br;
  logic [WIDTH-1:0] out_q;
  logic             borrow_q, overflow_q, zero_q;

  logic             ai, bi, d, br_next, last_bit;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    ai       = a_sr[0];
    bi       = b_sr[0];
    d        = ai ^ bi ^ br;
    br_next  = (~ai & bi) | (~(ai ^ bi) & br);
    res_next = {d, res_sr[WIDTH-1:1]};
    last_bit = (state == SHIFT) && (count == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (count == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      count      <= '0;
      br         <= 1'b0;
      out_q      <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            br    <= bus.borrow_in;
            count <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= br_next;
          count  <= count + CW'(1);
          // On the MSB step, br is still the borrow into the MSB, so it
          // serves directly as the captured bm for the overflow flag.
          if (last_bit) begin
            out_q      <= res_next;
            borrow_q   <= br_next;
            overflow_q <= br ^ br_next;
            zero_q     <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state == SHIFT);
  assign bus.done       = (state == DONE);
  assign bus.out        = out_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = overflow_q;
  assign bus.zero       = zero_q;

endmodule
